// File: rtl/exec_alu_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module     : exec_alu_regfile_if
//  Description: Bundle of the execute-stage datapath signals: the two
//               register read ports, the single write port and the ALU
//               operand/result lines.
//  Modports   : master - decode/execute/writeback side (drives addresses,
//                        write data, operands and op; observes results)
//               slave  - exec_alu_regfile (observes requests, drives
//                        readdata1/2, lo, hi, zero)
//  Revision   : 1.0 - initial release
// ============================================================================
interface exec_alu_regfile_if;
    logic [4:0]  readaddr1;
    logic [4:0]  readaddr2;
    logic [31:0] readdata1;
    logic [31:0] readdata2;
    logic        we;
    logic [4:0]  writeaddr;
    logic [31:0] writedata;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [3:0]  op;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;

    modport master (
        output readaddr1, readaddr2, we, writeaddr, writedata,
        output a, b, shamt, op,
        input  readdata1, readdata2, lo, hi, zero
    );

    modport slave (
        input  readaddr1, readaddr2, we, writeaddr, writedata,
        input  a, b, shamt, op,
        output readdata1, readdata2, lo, hi, zero
    );
endinterface
`default_nettype wire

// File: rtl/exec_alu_regfile.sv
`default_nettype none
// ============================================================================
//  Module     : exec_alu_regfile
//  Description: Execute-stage datapath core. 32x32 register file with two
//               combinational read ports (with write-to-read bypass) and one
//               clocked write port, plus a fully combinational 32-bit ALU
//               producing lo/hi/zero.
//  Ports      : clk  - rising-edge clock
//               rst  - synchronous active-high reset, clears all registers
//               bus  - exec_alu_regfile_if.slave (register ports + ALU)
//  Revision   : 1.0 - initial release
// ============================================================================
module exec_alu_regfile (
    input  wire                       clk,
    input  wire                       rst,
    exec_alu_regfile_if.slave         bus
);

    // ALU operation encodings
    localparam logic [3:0] c_OP_AND   = 4'b0000;
    localparam logic [3:0] c_OP_OR    = 4'b0001;
    localparam logic [3:0] c_OP_XOR   = 4'b0010;
    localparam logic [3:0] c_OP_NOR   = 4'b0011;
    localparam logic [3:0] c_OP_ADD   = 4'b0100;
    localparam logic [3:0] c_OP_SUB   = 4'b0101;
    localparam logic [3:0] c_OP_SLT   = 4'b0110;
    localparam logic [3:0] c_OP_SLTU  = 4'b0111;
    localparam logic [3:0] c_OP_SLL   = 4'b1000;
    localparam logic [3:0] c_OP_SRL   = 4'b1001;
    localparam logic [3:0] c_OP_SRA   = 4'b1010;
    localparam logic [3:0] c_OP_MULT  = 4'b1011;
    localparam logic [3:0] c_OP_MULTU = 4'b1100;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [31:0] r_mem [32];
    logic        w_wr_en;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;

    // Register 0 is hardwired to zero, so writes to it are dropped here
    // and the bypass path never forwards them either.
    assign w_wr_en = bus.we && (bus.writeaddr != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_wr_en) begin
            r_mem[bus.writeaddr] <= bus.writedata;
        end
    end

    // Same-cycle bypass lets writeback and decode share a cycle without a
    // stall. The zero check keeps r0 reading 0 even if r_mem[0] were
    // somehow nonzero.
    always_comb begin
        w_rd1 = 32'd0;
        w_rd2 = 32'd0;
        if (bus.readaddr1 != 5'd0) begin
            if (w_wr_en && (bus.writeaddr == bus.readaddr1)) begin
                w_rd1 = bus.writedata;
            end else begin
                w_rd1 = r_mem[bus.readaddr1];
            end
        end
        if (bus.readaddr2 != 5'd0) begin
            if (w_wr_en && (bus.writeaddr == bus.readaddr2)) begin
                w_rd2 = bus.writedata;
            end else begin
                w_rd2 = r_mem[bus.readaddr2];
            end
        end
    end

    assign bus.readdata1 = w_rd1;
    assign bus.readdata2 = w_rd2;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic        [31:0] w_sra;
    logic        [31:0] w_lo;
    logic        [31:0] w_hi;

    // Operands are widened to 64 bits (sign- or zero-extended) so the
    // product keeps its full width in both multiply flavours.
    assign w_prod_s = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
    assign w_prod_u = {32'd0, bus.a} * {32'd0, bus.b};
    assign w_sra    = $signed(bus.b) >>> bus.shamt;

    always_comb begin
        w_lo = 32'd0;
        w_hi = 32'd0;
        case (bus.op)
            c_OP_AND:   w_lo = bus.a & bus.b;
            c_OP_OR:    w_lo = bus.a | bus.b;
            c_OP_XOR:   w_lo = bus.a ^ bus.b;
            c_OP_NOR:   w_lo = ~(bus.a | bus.b);
            c_OP_ADD:   w_lo = bus.a + bus.b;
            c_OP_SUB:   w_lo = bus.a - bus.b;
            c_OP_SLT:   w_lo = {31'd0, ($signed(bus.a) < $signed(bus.b))};
            c_OP_SLTU:  w_lo = {31'd0, (bus.a < bus.b)};
            c_OP_SLL:   w_lo = bus.b << bus.shamt;
            c_OP_SRL:   w_lo = bus.b >> bus.shamt;
            c_OP_SRA:   w_lo = w_sra;
            c_OP_MULT: begin
                w_lo = w_prod_s[31:0];
                w_hi = w_prod_s[63:32];
            end
            c_OP_MULTU: begin
                w_lo = w_prod_u[31:0];
                w_hi = w_prod_u[63:32];
            end
            default:    w_lo = 32'd0;
        endcase
    end

    assign bus.lo   = w_lo;
    assign bus.hi   = w_hi;
    assign bus.zero = (w_lo == 32'd0);

endmodule
`default_nettype wire

// File: tb/tb_exec_alu_regfile.sv
`default_nettype none
// ============================================================================
//  Module     : tb_exec_alu_regfile
//  Description: Directed testbench for exec_alu_regfile. Stimulus tasks push
//               hand-computed expectations into a queue; a monitor drains
//               and compares them on the falling edge of each cycle.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_exec_alu_regfile;

    localparam int K_RD1  = 0;
    localparam int K_RD2  = 1;
    localparam int K_LO   = 2;
    localparam int K_HI   = 3;
    localparam int K_ZERO = 4;

    typedef struct {
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    exp_t q_exp[$];
    int   checks;
    int   errors;

    exec_alu_regfile_if bus ();

    exec_alu_regfile u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: everything expected in a cycle is compared mid-cycle.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                case (e.kind)
                    K_RD1:   act = bus.readdata1;
                    K_RD2:   act = bus.readdata2;
                    K_LO:    act = bus.lo;
                    K_HI:    act = bus.hi;
                    default: act = {31'd0, bus.zero};
                endcase
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
                end
            end
        end
    end

    function automatic void push(input int kind, input logic [31:0] val, input string name);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        q_exp.push_back(e);
    endfunction

    task automatic idle_inputs();
        bus.we        = 1'b0;
        bus.writeaddr = 5'd0;
        bus.writedata = 32'd0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        bus.shamt     = 5'd0;
        bus.op        = 4'b1111;
    endtask

    // Read both ports in one cycle with no write active.
    task automatic rd(input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] e1, input logic [31:0] e2, input string nm);
        @(posedge clk); #1;
        idle_inputs();
        bus.readaddr1 = a1;
        bus.readaddr2 = a2;
        push(K_RD1, e1, {nm, "_rd1"});
        push(K_RD2, e2, {nm, "_rd2"});
    endtask

    // Write cycle; both read ports are checked before the edge commits.
    task automatic wr(input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] e1, input logic [31:0] e2, input string nm);
        @(posedge clk); #1;
        idle_inputs();
        bus.we        = 1'b1;
        bus.writeaddr = wa;
        bus.writedata = wd;
        bus.readaddr1 = a1;
        bus.readaddr2 = a2;
        push(K_RD1, e1, {nm, "_rd1"});
        push(K_RD2, e2, {nm, "_rd2"});
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] elo, input logic [31:0] ehi,
                       input string nm);
        @(posedge clk); #1;
        idle_inputs();
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.shamt = sh;
        push(K_LO, elo, {nm, "_lo"});
        push(K_HI, ehi, {nm, "_hi"});
        push(K_ZERO, (elo == 32'd0) ? 32'd1 : 32'd0, {nm, "_zero"});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.readaddr1 = 5'd0;
        bus.readaddr2 = 5'd0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state of every register on both ports
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i), 32'd0, 32'd0, "reset");
        end

        // Basic write then read back
        wr(5'd5, 32'h1234_5678, 5'd1, 5'd2, 32'd0, 32'd0, "wr_r5");
        rd(5'd5, 5'd0, 32'h1234_5678, 32'd0, "rd_r5");

        // r0 is immune to writes and never bypasses
        wr(5'd0, 32'hFFFF_FFFF, 5'd0, 5'd5, 32'd0, 32'h1234_5678, "wr_r0");
        rd(5'd0, 5'd0, 32'd0, 32'd0, "rd_r0");

        // Bypass on both ports at once, then the committed value
        wr(5'd7, 32'hA5A5_0000, 5'd7, 5'd7, 32'hA5A5_0000, 32'hA5A5_0000, "bypass_r7");
        rd(5'd7, 5'd5, 32'hA5A5_0000, 32'h1234_5678, "rd_r7");

        // Overwrite: bypass wins over the stored value
        wr(5'd5, 32'hDEAD_BEEF, 5'd7, 5'd5, 32'hA5A5_0000, 32'hDEAD_BEEF, "ovr_r5");
        rd(5'd5, 5'd7, 32'hDEAD_BEEF, 32'hA5A5_0000, "rd_ovr_r5");

        // Reset with a simultaneous write: the write is lost
        @(posedge clk); #1;
        idle_inputs();
        rst           = 1'b1;
        bus.we        = 1'b1;
        bus.writeaddr = 5'd9;
        bus.writedata = 32'h5555_AAAA;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        rd(5'd5, 5'd9, 32'd0, 32'd0, "rst_clear");
        rd(5'd7, 5'd7, 32'd0, 32'd0, "rst_clear_r7");

        // ALU vectors
        alu(4'b0100, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 32'd0, "add_wrap");
        alu(4'b0101, 32'd5, 32'd5, 5'd0, 32'd0, 32'd0, "sub_eq");
        alu(4'b0101, 32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE, 32'd0, "sub_neg");
        alu(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 32'd0, "and");
        alu(4'b0001, 32'h00FF_0000, 32'h0000_00FF, 5'd0, 32'h00FF_00FF, 32'd0, "or");
        alu(4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FF0_0FF0, 32'd0, "xor");
        alu(4'b0011, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 32'd0, "nor");
        alu(4'b1000, 32'hFFFF_FFFF, 32'h0000_ABCD, 5'd16, 32'hABCD_0000, 32'd0, "sll16");
        alu(4'b1000, 32'hFFFF_FFFF, 32'h0000_ABCD, 5'd0, 32'h0000_ABCD, 32'd0, "sll0");
        alu(4'b1001, 32'h1234_5678, 32'h8000_0000, 5'd4, 32'h0800_0000, 32'd0, "srl");
        alu(4'b1010, 32'h1234_5678, 32'h8000_0000, 5'd4, 32'hF800_0000, 32'd0, "sra");
        alu(4'b1011, 32'hFFFF_FFFE, 32'h0000_0003, 5'd0, 32'hFFFF_FFFA, 32'hFFFF_FFFF, "mult");
        alu(4'b1100, 32'hFFFF_FFFE, 32'h0000_0003, 5'd0, 32'hFFFF_FFFA, 32'h0000_0002, "multu");
        alu(4'b0110, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'd1, 32'd0, "slt");
        alu(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'd0, 32'd0, "sltu");
        alu(4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'd0, 32'd0, "op_undef");

        // Let the monitor drain the last cycle, then confirm it did.
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
        checks++;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", q_exp.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
